// File: rtl/feature_bank_router_pkg.sv
// Shared constants and bank-state encoding for the feature bank router.
package feature_bank_router_pkg;

  // Default bank count and beat width used when the router is not overridden.
  localparam int NUM_FEATURE_BANKS  = 2;
  localparam int DEF_DATA_BUS_WIDTH = 32;

  // Occupancy of one feature buffer bank.
  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/feature_bank_state.sv
// Occupancy tracker for a single feature buffer bank: FREE -> FILLING -> FULL -> FREE.
module feature_bank_state
  import feature_bank_router_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_start,    // a beat was accepted into this bank
  input  logic i_last,     // that beat closes the tile
  input  logic i_release,  // compute is done with this bank
  output logic o_full
);

  bank_state_e r_state, w_next;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= BANK_FREE;
    else     r_state <= w_next;
  end

  // Next state; a single-beat tile goes straight from FREE to FULL.
  always_comb begin
    w_next = r_state;
    case (r_state)
      BANK_FREE:    if (i_start) w_next = i_last ? BANK_FULL : BANK_FILLING;
      BANK_FILLING: if (i_start && i_last) w_next = BANK_FULL;
      BANK_FULL:    if (i_release) w_next = BANK_FREE;
      default:      w_next = BANK_FREE;
    endcase
  end

  assign o_full = (r_state == BANK_FULL);

endmodule

// File: rtl/feature_bank_router.sv
// Routes fetcher write beats into NUM_BANKS feature buffers with automatic
// ping-pong on end-of-tile, back-pressure on full banks and a legacy manual mode.
module feature_bank_router
  import feature_bank_router_pkg::*;
#(
  parameter int NUM_BANKS      = NUM_FEATURE_BANKS,
  parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
  parameter int ADDR_WIDTH     = 8,
  parameter int BANK_DEPTH     = 256,
  parameter int SEL_WIDTH      = $clog2(NUM_BANKS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                manual_mode,
  input  logic [SEL_WIDTH-1:0]                wr_sel,
  input  logic                                fetcher_to_mem,
  input  logic [ADDR_WIDTH-1:0]               wr_feature_addr,
  input  logic [DATA_BUS_WIDTH-1:0]           wr_feature_data,
  input  logic                                wr_last,
  output logic                                wr_ready,
  output logic [NUM_BANKS-1:0]                bank_wr_en,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]     bank_wr_addr,
  output logic [NUM_BANKS*DATA_BUS_WIDTH-1:0] bank_wr_data,
  output logic [NUM_BANKS-1:0]                bank_full,
  input  logic [NUM_BANKS-1:0]                bank_release,
  output logic [SEL_WIDTH-1:0]                fill_bank,
  output logic [ADDR_WIDTH:0]                 tile_words,
  output logic                                overflow_err
);

  localparam int                   CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]     DEPTH_C   = CNT_W'(BANK_DEPTH);
  localparam logic [SEL_WIDTH-1:0] LAST_BANK = SEL_WIDTH'(NUM_BANKS - 1);

  logic [NUM_BANKS-1:0]                     w_full;
  logic [NUM_BANKS-1:0]                     w_hit;
  logic                                     w_fill_full;
  logic                                     w_accept;
  logic                                     w_auto_acc;
  logic [SEL_WIDTH-1:0]                     w_tgt;
  logic [SEL_WIDTH-1:0]                     r_fill;
  logic [CNT_W-1:0]                         r_cnt;
  logic [CNT_W-1:0]                         r_tile_words;
  logic                                     r_ovf;
  logic [NUM_BANKS-1:0]                     r_en;
  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]     r_addr;
  logic [NUM_BANKS-1:0][DATA_BUS_WIDTH-1:0] r_data;

  // Occupancy of the bank currently being filled (drives back-pressure).
  always_comb begin
    w_fill_full = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (r_fill == SEL_WIDTH'(i)) w_fill_full = w_full[i];
  end

  // Ready depends only on registered state, never on fetcher_to_mem.
  assign wr_ready   = !rst && (manual_mode || !w_fill_full);
  assign w_accept   = fetcher_to_mem && wr_ready;
  assign w_auto_acc = w_accept && !manual_mode;
  assign w_tgt      = manual_mode ? wr_sel : r_fill;

  // One-hot bank hit; an out-of-range manual select hits nothing and the beat is dropped.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (w_accept && (w_tgt == SEL_WIDTH'(i))) w_hit[i] = 1'b1;
  end

  // Manual mode freezes occupancy: no starts, no releases.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    feature_bank_state u_state (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_hit[g] && !manual_mode),
      .i_last    (wr_last),
      .i_release (bank_release[g] && !manual_mode),
      .o_full    (w_full[g])
    );
  end

  // Registered bank write ports; non-selected banks are held at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_en[i]   <= w_hit[i];
        r_addr[i] <= w_hit[i] ? wr_feature_addr : '0;
        r_data[i] <= w_hit[i] ? wr_feature_data : '0;
      end
    end
  end

  // Tile bookkeeping in auto mode: beat count, completed-tile size, bank advance, overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill       <= '0;
      r_cnt        <= '0;
      r_tile_words <= '0;
      r_ovf        <= 1'b0;
    end else if (w_auto_acc) begin
      if (r_cnt == DEPTH_C) r_ovf <= 1'b1;
      if (wr_last) begin
        r_tile_words <= r_cnt + 1'b1;
        r_cnt        <= '0;
        r_fill       <= (r_fill == LAST_BANK) ? '0 : r_fill + 1'b1;
      end else if (r_cnt != DEPTH_C) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bank_wr_en   = r_en;
  assign bank_wr_addr = r_addr;
  assign bank_wr_data = r_data;
  assign bank_full    = w_full;
  assign fill_bank    = r_fill;
  assign tile_words   = r_tile_words;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_feature_bank_router.sv
// Directed plus randomized stimulus for feature_bank_router, checked every cycle
// against a behavioural occupancy/routing model.
module tb_feature_bank_router;

  localparam int NB = 2, DW = 16, AW = 8, DEPTH = 4, SW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             manual_mode = 1'b0;
  logic [SW-1:0]    wr_sel = '0;
  logic             fetcher_to_mem = 1'b0;
  logic [AW-1:0]    wr_feature_addr = '0;
  logic [DW-1:0]    wr_feature_data = '0;
  logic             wr_last = 1'b0;
  logic             wr_ready;
  logic [NB-1:0]    bank_wr_en;
  logic [NB*AW-1:0] bank_wr_addr;
  logic [NB*DW-1:0] bank_wr_data;
  logic [NB-1:0]    bank_full;
  logic [NB-1:0]    bank_release = '0;
  logic [SW-1:0]    fill_bank;
  logic [AW:0]      tile_words;
  logic             overflow_err;

  feature_bank_router #(
    .NUM_BANKS(NB), .DATA_BUS_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_DEPTH(DEPTH), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .manual_mode(manual_mode), .wr_sel(wr_sel),
    .fetcher_to_mem(fetcher_to_mem), .wr_feature_addr(wr_feature_addr),
    .wr_feature_data(wr_feature_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr), .bank_wr_data(bank_wr_data),
    .bank_full(bank_full), .bank_release(bank_release), .fill_bank(fill_bank),
    .tile_words(tile_words), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Model: per-bank occupancy (0 free, 1 filling, 2 full) plus tile bookkeeping.
  int m_st[NB];
  int m_fill = 0, m_cnt = 0, m_tw = 0;
  bit m_ovf = 1'b0;
  bit m_en[NB];
  int m_addr[NB], m_data[NB];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (manual_mode) return 1'b1;
    return m_st[m_fill] != 2;
  endfunction

  // Advance the model by one clock using the inputs presented in that cycle.
  task automatic m_step();
    bit acc;
    int tgt;
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        m_st[b] = 0; m_en[b] = 0; m_addr[b] = 0; m_data[b] = 0;
      end
      m_fill = 0; m_cnt = 0; m_tw = 0; m_ovf = 0;
      return;
    end
    acc = fetcher_to_mem && m_ready();
    tgt = manual_mode ? int'(wr_sel) : m_fill;
    for (int b = 0; b < NB; b++) begin
      m_en[b]   = acc && (tgt == b);
      m_addr[b] = m_en[b] ? int'(wr_feature_addr) : 0;
      m_data[b] = m_en[b] ? int'(wr_feature_data) : 0;
    end
    if (!manual_mode) begin
      for (int b = 0; b < NB; b++)
        if (bank_release[b] && m_st[b] == 2) m_st[b] = 0;
      if (acc) begin
        if (m_cnt == DEPTH) m_ovf = 1'b1;
        m_st[m_fill] = wr_last ? 2 : 1;
        if (wr_last) begin
          m_tw   = m_cnt + 1;
          m_cnt  = 0;
          m_fill = (m_fill + 1) % NB;
        end else if (m_cnt < DEPTH) begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic chk_outputs();
    logic [NB-1:0]    een, ef;
    logic [NB*AW-1:0] ea;
    logic [NB*DW-1:0] ed;
    for (int b = 0; b < NB; b++) begin
      een[b]         = m_en[b];
      ef[b]          = (m_st[b] == 2);
      ea[b*AW +: AW] = AW'(m_addr[b]);
      ed[b*DW +: DW] = DW'(m_data[b]);
    end
    chk("bank_wr_en",   bank_wr_en,   een);
    chk("bank_wr_addr", bank_wr_addr, ea);
    chk("bank_wr_data", bank_wr_data, ed);
    chk("bank_full",    bank_full,    ef);
    chk("fill_bank",    fill_bank,    m_fill);
    chk("tile_words",   tile_words,   m_tw);
    chk("overflow_err", overflow_err, m_ovf);
  endtask

  // Inputs are set just after a rising edge; ready is checked mid-cycle, outputs after the edge.
  task automatic tick();
    #2;
    chk("wr_ready", wr_ready, m_ready());
    @(posedge clk);
    m_step();
    #1;
    chk_outputs();
  endtask

  task automatic drive(input bit f, input bit l, input logic [NB-1:0] rel);
    fetcher_to_mem  = f;
    wr_last         = l;
    bank_release    = rel;
    wr_feature_addr = AW'($urandom);
    wr_feature_data = DW'($urandom);
    tick();
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) drive(0, 0, '0);
    rst = 1'b0;

    // Two 4-beat tiles fill both banks; further beats are back-pressured.
    for (int i = 0; i < 4; i++) drive(1, i == 3, '0);
    for (int i = 0; i < 4; i++) drive(1, i == 3, '0);
    drive(1, 0, '0);

    // Release bank 0 with the fetcher holding valid; beat lands next cycle.
    drive(1, 0, 2'b01);
    drive(1, 0, '0);
    // Close bank 0 while releasing bank 1 in the same cycle.
    drive(1, 1, 2'b10);
    drive(0, 0, '0);

    // Manual mode: select bank 1, then an out-of-range select; last/release ignored.
    manual_mode = 1'b1;
    wr_sel = 2'd1;
    repeat (3) drive(1, 0, '0);
    wr_sel = 2'd3;
    repeat (2) drive(1, 1, 2'b11);
    drive(0, 0, '0);
    manual_mode = 1'b0;

    // Overflow: 6 beats into a depth-4 bank, flag stays set afterwards.
    for (int i = 0; i < 6; i++) drive(1, i == 5, '0);
    repeat (2) drive(0, 0, '0);
    drive(0, 0, 2'b11);

    // Reset mid-tile, then a fresh tile restarting at bank 0.
    repeat (2) drive(1, 0, '0);
    rst = 1'b1;
    drive(1, 0, '0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, i == 2, '0);

    // Randomized traffic; mode only changes between tiles.
    for (int c = 0; c < 1500; c++) begin
      if (c % 40 == 0 && m_cnt == 0) manual_mode = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      wr_sel = SW'($urandom_range(0, 3));
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
            {($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
